// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel registered multiplexer.
//   state_t : output-register occupancy (ST_EMPTY / ST_FULL)
//   idx_w() : channel-index width for a given channel count (minimum 1 bit)
package mux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first asserted request scanning from ptr
// upward, wrapping modulo N. Purely combinational.
// Ports:
//   req   in  N   request vector
//   ptr   in  SW  scan start index (< N)
//   grant out SW  index of the first request found (0 when none)
//   found out 1   at least one request asserted
module rr_pick
  import mux_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          found
);

  logic [SW-1:0] idx;

  // First hit wins; later hits are masked by found.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx = SW'((32'(ptr) + 32'(i)) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/mux_nch_pipe.sv
// N-channel, W-bit registered multiplexer with valid/ready handshakes.
// One channel is chosen per transfer, from sel (rr_mode=0) or by internal
// round-robin (rr_mode=1), and held in a one-entry output register.
// Optional feature macro: MUXP_PARITY_EN adds the Y_par output (even parity of Y).
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   in_valid   in  N    per-channel valid
//   in_ready   out N    per-channel accept, one-hot or zero
//   I          in  N*W  channel data, channel k = I[k*W +: W]
//   sel        in  SW   external channel select
//   rr_mode    in  1    0 = external select, 1 = round-robin
//   out_valid  out 1    output register holds a word
//   out_ready  in  1    downstream accept
//   Y          out W    registered data
//   out_ch     out SW   channel that produced Y
//   Y_par      out 1    parity of Y (only with MUXP_PARITY_EN)
//   sel_err    out 1    one-cycle pulse after an out-of-range sel while able to load
module mux_nch_pipe
  import mux_pkg::*;
#(
  parameter  int unsigned W  = 8,
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N*W-1:0]  I,
  input  logic [SW-1:0]   sel,
  input  logic            rr_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    Y,
  output logic [SW-1:0]   out_ch,
`ifdef MUXP_PARITY_EN
  output logic            Y_par,
`endif
  output logic            sel_err
);

  state_t        state;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] grant;
  logic          found;
  logic [SW-1:0] c;
  logic          c_ok;
  logic          load_en;
  logic          sel_bad;
  logic          xfer;
  logic [W-1:0]  d;

  rr_pick #(.N(N)) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .found (found)
  );

  assign out_valid = (state == ST_FULL);

  // Channel choice, handshake and data select.
  always_comb begin
    load_en  = !out_valid || out_ready;
    sel_bad  = 32'(sel) >= N;
    c        = rr_mode ? grant : sel;
    c_ok     = rr_mode ? found : !sel_bad;
    in_ready = '0;
    if (load_en && c_ok) in_ready = N'(1) << c;
    xfer     = |(in_ready & in_valid);
    // Loop select keeps an out-of-range c from indexing past I.
    d = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (c == SW'(k)) d = I[k*W +: W];
    end
  end

  // Occupancy FSM, output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      Y       <= '0;
      out_ch  <= '0;
      sel_err <= 1'b0;
      rr_ptr  <= '0;
`ifdef MUXP_PARITY_EN
      Y_par   <= 1'b0;
`endif
    end else begin
      sel_err <= !rr_mode && load_en && sel_bad;
      case (state)
        ST_EMPTY: if (xfer) state <= ST_FULL;
        ST_FULL:  if (out_ready && !xfer) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
      if (xfer) begin
        Y      <= d;
        out_ch <= c;
`ifdef MUXP_PARITY_EN
        Y_par  <= ^d;
`endif
        if (rr_mode) rr_ptr <= (32'(c) == N - 1) ? '0 : SW'(32'(c) + 1);
      end
    end
  end

endmodule

// File: tb/tb_mux_nch_pipe.sv
module tb_mux_nch_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  iv4, rdy4;
  logic [31:0] d4;
  logic [1:0]  sel4, ch4;
  logic [7:0]  y4;
  logic        ov4, err4;

  logic [2:0]  iv3, rdy3;
  logic [23:0] d3;
  logic [1:0]  sel3, ch3;
  logic [7:0]  y3;
  logic        ov3, err3;

  logic rr, ordy;
`ifdef MUXP_PARITY_EN
  logic par4, par3;
`endif

  mux_nch_pipe #(.W(8), .N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .I(d4), .sel(sel4),
    .rr_mode(rr), .out_valid(ov4), .out_ready(ordy), .Y(y4), .out_ch(ch4),
`ifdef MUXP_PARITY_EN
    .Y_par(par4),
`endif
    .sel_err(err4)
  );

  mux_nch_pipe #(.W(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(rdy3), .I(d3), .sel(sel3),
    .rr_mode(rr), .out_valid(ov3), .out_ready(ordy), .Y(y3), .out_ch(ch3),
`ifdef MUXP_PARITY_EN
    .Y_par(par3),
`endif
    .sel_err(err3)
  );

  // Behavioural model: one entry per DUT.
  typedef struct {
    logic       v;
    logic [7:0] y;
    int         ch;
    logic       err;
    int         ptr;
    logic       par;
  } m_t;

  m_t m4, m3;
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chosen channel, or -1 when nothing can be chosen.
  function automatic int pick(int n, logic rrm, int s, logic [3:0] v, int ptr);
    int k;
    if (!rrm) return (s < n) ? s : -1;
    for (int i = 0; i < n; i++) begin
      k = (ptr + i) % n;
      if (v[k[1:0]]) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int n, m_t m, logic rrm, int s, logic [3:0] v, logic ordy_i);
    int c;
    if (m.v && !ordy_i) return 4'b0;
    c = pick(n, rrm, s, v, m.ptr);
    if (c < 0) return 4'b0;
    return 4'b1 << c;
  endfunction

  function automatic m_t step(int n, m_t m, logic rrm, int s, logic [3:0] v,
                              logic [31:0] data, logic ordy_i);
    m_t   r;
    int   c;
    logic load;
    r     = m;
    load  = !m.v || ordy_i;
    c     = pick(n, rrm, s, v, m.ptr);
    r.err = load && !rrm && (s >= n);
    if (load && c >= 0 && v[c[1:0]]) begin
      r.v   = 1'b1;
      r.y   = data[c*8 +: 8];
      r.ch  = c;
      r.par = ^r.y;
      if (rrm) r.ptr = (c + 1) % n;
    end else if (m.v && ordy_i) begin
      r.v = 1'b0;
    end
    return r;
  endfunction

  function automatic m_t m_reset();
    m_t r;
    r.v = 1'b0; r.y = 8'h0; r.ch = 0; r.err = 1'b0; r.ptr = 0; r.par = 1'b0;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4 <= m_reset();
      m3 <= m_reset();
    end else begin
      m4 <= step(4, m4, rr, int'(sel4), iv4, d4, ordy);
      m3 <= step(3, m3, rr, int'(sel3), {1'b0, iv3}, {8'h0, d3}, ordy);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ov4",  ov4,  m4.v);
    chk("y4",   y4,   m4.y);
    chk("ch4",  ch4,  m4.ch);
    chk("err4", err4, m4.err);
    chk("rdy4", rdy4, exp_ready(4, m4, rr, int'(sel4), iv4, ordy));
    chk("ov3",  ov3,  m3.v);
    chk("y3",   y3,   m3.y);
    chk("ch3",  ch3,  m3.ch);
    chk("err3", err3, m3.err);
    chk("rdy3", rdy3, exp_ready(3, m3, rr, int'(sel3), {1'b0, iv3}, ordy));
`ifdef MUXP_PARITY_EN
    chk("par4", par4, m4.par);
    chk("par3", par3, m3.par);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int         t3_ch [5] = '{0, 1, 2, 3, 0};
  logic [7:0] t3_y  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

  initial begin
    iv4 = '0; d4 = '0; sel4 = '0;
    iv3 = '0; d3 = '0; sel3 = '0;
    rr = 1'b0; ordy = 1'b1;
    cyc(); cyc();
    chk("rst_ov", ov4, 0);
    chk("rst_y", y4, 0);
    chk("rst_ch", ch4, 0);
    chk("rst_err", err4, 0);
    rst = 1'b0;

    // 1: external select of channel 2
    sel4 = 2'd2; d4 = 32'h00A5_0000; iv4 = 4'b0100;
    #1 chk("t1_rdy", rdy4, 4'b0100);
    cyc();
    chk("t1_ov", ov4, 1); chk("t1_y", y4, 8'hA5); chk("t1_ch", ch4, 2);

    // 2: stall while FULL, then pop and push in the same cycle
    ordy = 1'b0; d4 = 32'h003C_0000;
    #1 chk("t2_rdy_stall", rdy4, 4'b0000);
    repeat (3) begin
      cyc();
      chk("t2_hold_y", y4, 8'hA5);
      chk("t2_hold_ov", ov4, 1);
    end
    ordy = 1'b1; d4 = 32'h005A_0000;
    #1 chk("t2_rdy_go", rdy4, 4'b0100);
    cyc();
    chk("t2_push_y", y4, 8'h5A); chk("t2_push_ov", ov4, 1);

    // 3: round-robin over all channels with wrap
    rr = 1'b1; iv4 = 4'b1111; d4 = 32'h4433_2211;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_ch", ch4, t3_ch[i]);
      chk("t3_y", y4, t3_y[i]);
    end

    // 4: pointer at 3, only channel 1 requesting
    iv4 = 4'b0100;
    cyc();
    chk("t4_pre_ch", ch4, 2);
    iv4 = 4'b0010;
    #1 chk("t4_rdy", rdy4, 4'b0010);
    cyc();
    chk("t4_ch", ch4, 1);
    iv4 = 4'b1111;
    #1 chk("t4_ptr2_rdy", rdy4, 4'b0100);
    cyc();
    chk("t4_ptr2_ch", ch4, 2);

    // 5: N=3 with out-of-range select
    rr = 1'b0; iv4 = '0; sel4 = '0;
    iv3 = 3'b111; sel3 = 2'd3; d3 = 24'h33_2211;
    #1 chk("t5_rdy3", rdy3, 3'b000);
    cyc();
    chk("t5_err", err3, 1); chk("t5_ov3", ov3, 0);
    iv3 = '0; sel3 = 2'd0;
    cyc();
    chk("t5_err_clr", err3, 0);
    sel3 = 2'd1; iv3 = 3'b010; d3 = 24'h00_7700;
    cyc();
    chk("t5_y3", y3, 8'h77); chk("t5_ch3", ch3, 1); chk("t5_ov3_load", ov3, 1);

    // 6: reset while FULL and stalled
    iv3 = '0;
    sel4 = 2'd3; iv4 = 4'b1000; d4 = 32'h0700_0000;
    cyc();
    chk("t6_y", y4, 8'h07); chk("t6_ch", ch4, 3);
`ifdef MUXP_PARITY_EN
    chk("t6_par", par4, 1);
`endif
    ordy = 1'b0; iv4 = '0;
    cyc();
    chk("t6_full", ov4, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_ov", ov4, 0); chk("t6_rst_y", y4, 0);
    chk("t6_rst_ch", ch4, 0); chk("t6_rst_err", err4, 0);
    cyc();
    rst = 1'b0; rr = 1'b1; iv4 = 4'b1111; d4 = 32'h4433_2211; ordy = 1'b1;
    #1 chk("t6_rr_rdy", rdy4, 4'b0001);
    cyc();
    chk("t6_rr_ch", ch4, 0); chk("t6_rr_y", y4, 8'h11);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
